// File: rtl/pb_wr_seq.sv
// rtl/pb_wr_seq.sv - PB write/read-sweep sequencer feeding the interleaver RAM
// Buffers one PB of symbols at linear addresses, then sweeps them out in order.
module pb_wr_seq #(
  parameter int D_WIDTH = 2,
  parameter int A_WIDTH = 12,
  parameter int OFS_520 = 0,
  parameter int OFS_136 = 2080,
  parameter int OFS_16  = 2624
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_pb_size,
  input  logic [D_WIDTH-1:0] i_in_data,
  input  logic               i_in_vld,
  output logic               o_in_rdy,
  output logic [D_WIDTH-1:0] o_wdata,
  output logic [A_WIDTH-1:0] o_waddr,
  output logic [A_WIDTH-1:0] o_pb_offset,
  output logic               o_din_vld,
  output logic               o_rd_en,
  output logic               o_rd_vld,
  output logic               o_blk_done,
  output logic               o_busy,
  output logic               o_size_err
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_TAIL} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [A_WIDTH-1:0] r_cnt;
  logic [A_WIDTH-1:0] r_n;
  logic [A_WIDTH-1:0] r_waddr;
  logic [A_WIDTH-1:0] r_pb_offset;
  logic [D_WIDTH-1:0] r_wdata;
  logic               r_din_vld;
  logic               r_rd_en;
  logic               r_rd_last;
  logic               r_rd_d1;
  logic               r_last_d1;
  logic               r_rd_vld;
  logic               r_blk_done;
  logic               r_busy;
  logic               r_size_err;

  logic [A_WIDTH-1:0] w_last_idx;
  logic [A_WIDTH-1:0] w_n_sel;
  logic [A_WIDTH-1:0] w_ofs_sel;
  logic               w_cnt_last;
  logic               w_beat;
  logic               w_start_ok;
  logic               w_start_bad;

  assign o_in_rdy    = (r_state == S_WRITE);
  assign w_beat      = o_in_rdy & i_in_vld;
  assign w_last_idx  = r_n - A_WIDTH'(1);
  assign w_cnt_last  = (r_cnt == w_last_idx);
  assign w_start_ok  = (r_state == S_IDLE) & i_start & (i_pb_size != 2'd3);
  assign w_start_bad = (r_state == S_IDLE) & i_start & (i_pb_size == 2'd3);

  always_comb begin
    w_n_sel   = A_WIDTH'(2080);
    w_ofs_sel = A_WIDTH'(OFS_520);
    case (i_pb_size)
      2'd0: begin
        w_n_sel   = A_WIDTH'(64);
        w_ofs_sel = A_WIDTH'(OFS_16);
      end
      2'd1: begin
        w_n_sel   = A_WIDTH'(544);
        w_ofs_sel = A_WIDTH'(OFS_136);
      end
      default: begin
        w_n_sel   = A_WIDTH'(2080);
        w_ofs_sel = A_WIDTH'(OFS_520);
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_WRITE;
      S_WRITE: if (w_beat && w_cnt_last) w_next = S_READ;
      S_READ:  if (w_cnt_last) w_next = S_TAIL;
      S_TAIL:  if (r_cnt == A_WIDTH'(1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Read-side completion travels with rd_en through the same 2-stage delay as rd_vld.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_n         <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_pb_offset <= '0;
      r_din_vld   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_d1     <= 1'b0;
      r_last_d1   <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_blk_done  <= 1'b0;
      r_busy      <= 1'b0;
      r_size_err  <= 1'b0;
    end else begin
      r_busy     <= (w_next != S_IDLE);
      r_size_err <= w_start_bad;
      r_din_vld  <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_d1    <= r_rd_en;
      r_rd_vld   <= r_rd_d1;
      r_last_d1  <= r_rd_last;
      r_blk_done <= r_last_d1;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_n         <= w_n_sel;
            r_pb_offset <= w_ofs_sel;
            r_cnt       <= '0;
          end
        end
        S_WRITE: begin
          if (w_beat) begin
            r_wdata   <= i_in_data;
            r_waddr   <= r_cnt;
            r_din_vld <= 1'b1;
            r_cnt     <= w_cnt_last ? '0 : r_cnt + A_WIDTH'(1);
          end
        end
        S_READ: begin
          r_rd_en   <= 1'b1;
          r_waddr   <= r_cnt;
          r_rd_last <= w_cnt_last;
          r_cnt     <= w_cnt_last ? '0 : r_cnt + A_WIDTH'(1);
        end
        S_TAIL: begin
          r_cnt <= (r_cnt == A_WIDTH'(1)) ? '0 : r_cnt + A_WIDTH'(1);
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_wdata     = r_wdata;
  assign o_waddr     = r_waddr;
  assign o_pb_offset = r_pb_offset;
  assign o_din_vld   = r_din_vld;
  assign o_rd_en     = r_rd_en;
  assign o_rd_vld    = r_rd_vld;
  assign o_blk_done  = r_blk_done;
  assign o_busy      = r_busy;
  assign o_size_err  = r_size_err;

endmodule

// File: tb/tb_pb_wr_seq.sv
// tb/tb_pb_wr_seq.sv - self-checking bench for pb_wr_seq
// Event logs are compared against per-block expectations derived from PB size rules.
module tb_pb_wr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  pb_size;
  logic [1:0]  in_data;
  logic        in_vld;
  logic        in_rdy;
  logic [1:0]  wdata;
  logic [11:0] waddr;
  logic [11:0] pb_offset;
  logic        din_vld;
  logic        rd_en;
  logic        rd_vld;
  logic        blk_done;
  logic        busy;
  logic        size_err;

  pb_wr_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pb_size(pb_size),
    .i_in_data(in_data), .i_in_vld(in_vld), .o_in_rdy(in_rdy),
    .o_wdata(wdata), .o_waddr(waddr), .o_pb_offset(pb_offset),
    .o_din_vld(din_vld), .o_rd_en(rd_en), .o_rd_vld(rd_vld),
    .o_blk_done(blk_done), .o_busy(busy), .o_size_err(size_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_ofs = 0;
  int ofs_bad = 0;

  logic [1:0] sent_q[$];
  logic [1:0] wr_data_q[$];
  int wr_addr_q[$];
  int wr_cyc_q[$];
  int rd_addr_q[$];
  int rd_cyc_q[$];
  int vld_cyc_q[$];
  int done_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (din_vld) begin
        wr_addr_q.push_back(int'(waddr));
        wr_data_q.push_back(wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (rd_en) begin
        rd_addr_q.push_back(int'(waddr));
        rd_cyc_q.push_back(cyc);
      end
      if (rd_vld) vld_cyc_q.push_back(cyc);
      if (blk_done) done_cyc_q.push_back(cyc);
      if (busy && int'(pb_offset) != exp_ofs) ofs_bad++;
    end
  end

  function automatic int blk_len(input int sz);
    return (sz == 0) ? 64 : (sz == 1) ? 544 : 2080;
  endfunction

  function automatic int blk_ofs(input int sz);
    return (sz == 0) ? 2624 : (sz == 1) ? 2080 : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_rdy"}, int'(in_rdy), 0);
    chk({tag, "_wdata"}, int'(wdata), 0);
    chk({tag, "_waddr"}, int'(waddr), 0);
    chk({tag, "_pb_offset"}, int'(pb_offset), 0);
    chk({tag, "_din_vld"}, int'(din_vld), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_vld"}, int'(rd_vld), 0);
    chk({tag, "_blk_done"}, int'(blk_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_size_err"}, int'(size_err), 0);
  endtask

  task automatic clear_mon();
    sent_q.delete();
    wr_data_q.delete();
    wr_addr_q.delete();
    wr_cyc_q.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    vld_cyc_q.delete();
    done_cyc_q.delete();
    ofs_bad = 0;
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge.
  task automatic run_block(input int sz, input int pct, input int poke_at,
                           input int abort_at, output bit aborted);
    int n;
    int got;
    int guard;
    n = blk_len(sz);
    got = 0;
    guard = 0;
    aborted = 1'b0;
    exp_ofs = blk_ofs(sz);
    start = 1'b1;
    pb_size = 2'(sz);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("in_rdy_after_start", int'(in_rdy), 1);
    while (got < n && guard < 20000) begin
      if (abort_at > 0 && got == abort_at) begin
        aborted = 1'b1;
        break;
      end
      in_vld = ($urandom_range(99) < pct);
      in_data = 2'($urandom_range(3));
      if (poke_at > 0 && got == poke_at) begin
        start = 1'b1;
        pb_size = 2'd0;
      end else begin
        start = 1'b0;
        pb_size = 2'(sz);
      end
      if (in_vld && in_rdy) begin
        sent_q.push_back(in_data);
        got++;
      end
      @(negedge clk);
      guard++;
    end
    in_vld = 1'b0;
    start = 1'b0;
    pb_size = 2'(sz);
    chk("write_phase_bound", int'(guard < 20000), 1);
    if (!aborted) begin
      chk("in_rdy_after_last_beat", int'(in_rdy), 0);
      guard = 0;
      while (busy && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      chk("busy_drop", int'(busy), 0);
    end
  endtask

  task automatic check_blocks(input int n, input int nb);
    int tot;
    int bad;
    tot = n * nb;
    chk("wr_count", wr_addr_q.size(), tot);
    chk("sent_count", sent_q.size(), tot);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < sent_q.size(); i++)
      if (wr_addr_q[i] != i % n || wr_data_q[i] !== sent_q[i]) bad++;
    chk("wr_seq", bad, 0);
    chk("rd_count", rd_addr_q.size(), tot);
    bad = 0;
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      if (rd_addr_q[i] != i % n) bad++;
      if (i % n != 0 && rd_cyc_q[i] != rd_cyc_q[i-1] + 1) bad++;
    end
    chk("rd_seq", bad, 0);
    chk("vld_count", vld_cyc_q.size(), tot);
    bad = 0;
    for (int i = 0; i < vld_cyc_q.size() && i < rd_cyc_q.size(); i++)
      if (vld_cyc_q[i] != rd_cyc_q[i] + 2) bad++;
    chk("vld_delay", bad, 0);
    chk("done_count", done_cyc_q.size(), nb);
    for (int b = 0; b < nb; b++) begin
      if (b < done_cyc_q.size() && b*n + n - 1 < vld_cyc_q.size())
        chk("done_on_last_vld", done_cyc_q[b], vld_cyc_q[b*n + n - 1]);
      if (b*n + n - 1 < wr_cyc_q.size() && b*n < rd_cyc_q.size())
        chk("rd_after_wr", int'(rd_cyc_q[b*n] > wr_cyc_q[b*n + n - 1]), 1);
    end
    chk("pb_offset_stable", ofs_bad, 0);
  endtask

  initial begin
    bit ab;
    rst = 1'b1;
    start = 1'b0;
    pb_size = 2'd0;
    in_data = 2'd0;
    in_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    start = 1'b1;
    pb_size = 2'd3;
    @(negedge clk);
    start = 1'b0;
    chk("size_err_pulse", int'(size_err), 1);
    chk("size_err_busy", int'(busy), 0);
    chk("size_err_in_rdy", int'(in_rdy), 0);
    @(negedge clk);
    chk("size_err_clear", int'(size_err), 0);
    chk("size_err_busy2", int'(busy), 0);
    chk("size_err_ofs", int'(pb_offset), 0);

    clear_mon();
    run_block(0, 100, 0, 0, ab);
    repeat (4) @(negedge clk);
    check_blocks(64, 1);

    clear_mon();
    run_block(2, 60, 0, 0, ab);
    repeat (4) @(negedge clk);
    check_blocks(2080, 1);

    clear_mon();
    run_block(1, 75, 200, 0, ab);
    repeat (4) @(negedge clk);
    check_blocks(544, 1);

    clear_mon();
    run_block(0, 80, 0, 0, ab);
    run_block(0, 100, 0, 0, ab);
    repeat (4) @(negedge clk);
    check_blocks(64, 2);

    clear_mon();
    run_block(1, 100, 0, 100, ab);
    chk("abort_reached", int'(ab), 1);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_done_after_abort", done_cyc_q.size(), 0);
    chk("idle_after_abort", int'(busy), 0);
    clear_mon();
    run_block(0, 100, 0, 0, ab);
    repeat (4) @(negedge clk);
    check_blocks(64, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
